// File: rtl/ysyx_22050078_pipectrl.sv
// Pipeline hazard/stall controller: per-stage write enables and bubble/flush
// requests for a five-stage core with a multi-cycle MDU and a stalling LSU.
module ysyx_22050078_pipectrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ldhzd,
  input  logic             i_bru_jump,
  input  logic             i_ifu_valid,
  input  logic             i_mdu_start,
  input  logic             i_mdu_done,
  input  logic             i_lsu_req,
  input  logic             i_lsu_ready,
  output logic             o_pc_wen,
  output logic             o_ifid_wen,
  output logic             o_idex_wen,
  output logic             o_exls_wen,
  output logic             o_lswb_wen,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_exls_bubble,
  output logic             o_lswb_bubble,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    EXWAIT  = 2'b01,
    MEMWAIT = 2'b10
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;
  logic             mdu_busy_r;
  logic             mdu_done_q_r;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             mem_stall_s;
  logic             done_any_s;
  logic [4:0]       wen_s;
  logic [3:0]       nop_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign mem_stall_s = i_lsu_req & ~i_lsu_ready;
  assign done_any_s  = mdu_done_q_r | i_mdu_done;

  // Next-state, MDU flag update and raw stage controls {pc,ifid,idex,exls,lswb}.
  always_comb begin
    state_nxt_s = state_r;
    busy_nxt_s  = mdu_busy_r;
    done_nxt_s  = mdu_done_q_r | (mdu_busy_r & i_mdu_done);
    wen_s       = 5'b00000;
    nop_s       = 4'b0000;
    if (mem_stall_s) begin
      // Only the LSU->WB register moves, and it takes a NOP.
      wen_s       = 5'b00001;
      nop_s       = 4'b0001;
      state_nxt_s = MEMWAIT;
    end else begin
      case (state_r)
        RUN: begin
          if (i_mdu_start) begin
            wen_s       = 5'b11111;
            state_nxt_s = EXWAIT;
            busy_nxt_s  = 1'b1;
            done_nxt_s  = 1'b0;
          end else if (i_ldhzd) begin
            wen_s = 5'b00111;
            nop_s = 4'b0100;
          end else if (i_bru_jump) begin
            wen_s = 5'b11111;
            nop_s = 4'b1000;
          end else if (!i_ifu_valid) begin
            wen_s = 5'b01111;
            nop_s = 4'b1000;
          end else begin
            wen_s = 5'b11111;
          end
        end
        EXWAIT: begin
          if (done_any_s) begin
            wen_s       = 5'b11111;
            state_nxt_s = RUN;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
          end else begin
            wen_s = 5'b00011;
            nop_s = 4'b0010;
          end
        end
        MEMWAIT: begin
          // Memory completed: resume whichever state the MDU status implies.
          if (mdu_busy_r && !done_any_s) begin
            wen_s       = 5'b00011;
            nop_s       = 4'b0010;
            state_nxt_s = EXWAIT;
          end else begin
            wen_s       = 5'b11111;
            state_nxt_s = RUN;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
          end
        end
        default: begin
          state_nxt_s = RUN;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and MDU tracking flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      mdu_busy_r   <= 1'b0;
      mdu_done_q_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mdu_busy_r   <= busy_nxt_s;
      mdu_done_q_r <= done_nxt_s;
    end
  end

  // Stall performance counter; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!wen_s[4]) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_pc_wen      = rst_n & wen_s[4];
  assign o_ifid_wen    = rst_n & wen_s[3];
  assign o_idex_wen    = rst_n & wen_s[2];
  assign o_exls_wen    = rst_n & wen_s[1];
  assign o_lswb_wen    = rst_n & wen_s[0];
  assign o_ifid_flush  = rst_n & nop_s[3];
  assign o_idex_bubble = rst_n & nop_s[2];
  assign o_exls_bubble = rst_n & nop_s[1];
  assign o_lswb_bubble = rst_n & nop_s[0];
  assign o_state       = state_r;
  assign o_stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_ysyx_22050078_pipectrl.sv
// Directed self-checking bench for ysyx_22050078_pipectrl (CNT_W=4 so the
// counter wrap is reachable quickly).
module tb_ysyx_22050078_pipectrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ldhzd, jump, ifu_valid, mdu_start, mdu_done, lsu_req, lsu_ready;
  logic       pc_wen, ifid_wen, idex_wen, exls_wen, lswb_wen;
  logic       ifid_flush, idex_bubble, exls_bubble, lswb_bubble;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [8:0] outs;
  int         tests = 0;
  int         fails = 0;

  localparam logic [8:0] ALL  = 9'b11111_0000;
  localparam logic [8:0] LDH  = 9'b00111_0100;
  localparam logic [8:0] JMP  = 9'b11111_1000;
  localparam logic [8:0] NOV  = 9'b01111_1000;
  localparam logic [8:0] EXW  = 9'b00011_0010;
  localparam logic [8:0] MEM  = 9'b00001_0001;
  localparam logic [8:0] ZERO = 9'b00000_0000;

  always #5 clk = ~clk;

  assign outs = {pc_wen, ifid_wen, idex_wen, exls_wen, lswb_wen,
                 ifid_flush, idex_bubble, exls_bubble, lswb_bubble};

  ysyx_22050078_pipectrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ldhzd(ldhzd), .i_bru_jump(jump), .i_ifu_valid(ifu_valid),
    .i_mdu_start(mdu_start), .i_mdu_done(mdu_done),
    .i_lsu_req(lsu_req), .i_lsu_ready(lsu_ready),
    .o_pc_wen(pc_wen), .o_ifid_wen(ifid_wen), .o_idex_wen(idex_wen),
    .o_exls_wen(exls_wen), .o_lswb_wen(lswb_wen),
    .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble),
    .o_exls_bubble(exls_bubble), .o_lswb_bubble(lswb_bubble),
    .o_state(state), .o_stall_cnt(cnt)
  );

  task automatic idle();
    ldhzd = 1'b0; jump = 1'b0; ifu_valid = 1'b1; mdu_start = 1'b0;
    mdu_done = 1'b0; lsu_req = 1'b0; lsu_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mdu_start = 1'b1; jump = 1'b1; lsu_req = 1'b1;
    #1;
    tests++; if (outs !== ZERO) begin fails++; $display("FAIL reset_outs got %b want %b", outs, ZERO); end
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state got %b want 00", state); end
    @(negedge clk); #1;
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    idle();
    rst_n = 1'b1;
    #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL reset_release got %b want %b", outs, ALL); end
  endtask

  task automatic test_ldhzd();
    do_reset();
    ldhzd = 1'b1; #1;
    tests++; if (outs !== LDH) begin fails++; $display("FAIL ldhzd_outs got %b want %b", outs, LDH); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL ldhzd_cnt0 got %0d want 0", cnt); end
    @(negedge clk); ldhzd = 1'b0; #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL ldhzd_after got %b want %b", outs, ALL); end
    tests++; if (cnt !== 4'd1) begin fails++; $display("FAIL ldhzd_cnt1 got %0d want 1", cnt); end
  endtask

  task automatic test_jump_hazard();
    do_reset();
    ldhzd = 1'b1; jump = 1'b1; #1;
    tests++; if (outs !== LDH) begin fails++; $display("FAIL jmp_hzd got %b want %b", outs, LDH); end
    @(negedge clk); ldhzd = 1'b0; #1;
    tests++; if (outs !== JMP) begin fails++; $display("FAIL jmp_alone got %b want %b", outs, JMP); end
    @(negedge clk); jump = 1'b0; ifu_valid = 1'b0; #1;
    tests++; if (outs !== NOV) begin fails++; $display("FAIL ifu_invalid got %b want %b", outs, NOV); end
    @(negedge clk); idle(); #1;
    tests++; if (cnt !== 4'd2) begin fails++; $display("FAIL jmp_cnt got %0d want 2", cnt); end
  endtask

  task automatic test_mdu();
    do_reset();
    mdu_start = 1'b1; #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL mdu_issue got %b want %b", outs, ALL); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ldhzd = 1'b1; jump = 1'b1; ifu_valid = 1'b0; mdu_start = 1'b1; #1;
      tests++; if (state !== 2'b01) begin fails++; $display("FAIL mdu_wait_state[%0d] got %b want 01", i, state); end
      tests++; if (outs !== EXW) begin fails++; $display("FAIL mdu_wait_outs[%0d] got %b want %b", i, outs, EXW); end
    end
    @(negedge clk); idle(); mdu_done = 1'b1; #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL mdu_done_outs got %b want %b", outs, ALL); end
    @(negedge clk); idle(); #1;
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL mdu_back_run got %b want 00", state); end
    tests++; if (cnt !== 4'd4) begin fails++; $display("FAIL mdu_cnt got %0d want 4", cnt); end
  endtask

  task automatic test_memwait();
    do_reset();
    mdu_start = 1'b1;
    @(negedge clk); idle();
    @(negedge clk); lsu_req = 1'b1; #1;
    tests++; if (state !== 2'b01) begin fails++; $display("FAIL mem_enter_state got %b want 01", state); end
    tests++; if (outs !== MEM) begin fails++; $display("FAIL mem_enter_outs got %b want %b", outs, MEM); end
    @(negedge clk); mdu_done = 1'b1; #1;
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL mem_w1_state got %b want 10", state); end
    tests++; if (outs !== MEM) begin fails++; $display("FAIL mem_w1_outs got %b want %b", outs, MEM); end
    @(negedge clk); mdu_done = 1'b0; #1;
    tests++; if (outs !== MEM) begin fails++; $display("FAIL mem_w2_outs got %b want %b", outs, MEM); end
    @(negedge clk); lsu_ready = 1'b1; #1;
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL mem_exit_state got %b want 10", state); end
    tests++; if (outs !== ALL) begin fails++; $display("FAIL mem_exit_outs got %b want %b", outs, ALL); end
    @(negedge clk); idle(); #1;
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL mem_to_run got %b want 00", state); end
    tests++; if (cnt !== 4'd4) begin fails++; $display("FAIL mem_cnt got %0d want 4", cnt); end
  endtask

  task automatic test_mem_to_exwait();
    do_reset();
    mdu_start = 1'b1;
    @(negedge clk); idle(); lsu_req = 1'b1;
    @(negedge clk); lsu_ready = 1'b1; #1;
    tests++; if (outs !== EXW) begin fails++; $display("FAIL mem_ret_ex_outs got %b want %b", outs, EXW); end
    @(negedge clk); idle(); #1;
    tests++; if (state !== 2'b01) begin fails++; $display("FAIL mem_ret_ex_state got %b want 01", state); end
    @(negedge clk); mdu_done = 1'b1; #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL mem_ret_done got %b want %b", outs, ALL); end
    @(negedge clk); idle(); #1;
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL mem_ret_run got %b want 00", state); end
  endtask

  task automatic test_memstall_run();
    do_reset();
    lsu_req = 1'b1; ldhzd = 1'b1; jump = 1'b1; #1;
    tests++; if (outs !== MEM) begin fails++; $display("FAIL run_mem_prio got %b want %b", outs, MEM); end
    @(negedge clk); idle(); lsu_req = 1'b1; lsu_ready = 1'b1; #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL run_mem_exit got %b want %b", outs, ALL); end
    @(negedge clk); idle(); #1;
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL run_mem_state got %b want 00", state); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      ldhzd = 1'b1;
      @(negedge clk);
    end
    ldhzd = 1'b0; #1;
    tests++; if (cnt !== 4'd15) begin fails++; $display("FAIL wrap_full got %0d want 15", cnt); end
    @(negedge clk); ldhzd = 1'b1;
    @(negedge clk); ldhzd = 1'b0; #1;
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL wrap_zero got %0d want 0", cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mdu_start = 1'b1;
    @(negedge clk); idle(); lsu_req = 1'b1;
    @(negedge clk); #1;
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL ares_pre got %b want 10", state); end
    #2; rst_n = 1'b0; #1;
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL ares_state got %b want 00", state); end
    tests++; if (outs !== ZERO) begin fails++; $display("FAIL ares_outs got %b want %b", outs, ZERO); end
    @(negedge clk); idle(); rst_n = 1'b1; #1;
    tests++; if (outs !== ALL) begin fails++; $display("FAIL ares_release got %b want %b", outs, ALL); end
    @(negedge clk); #1;
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL ares_run got %b want 00", state); end
    tests++; if (outs !== ALL) begin fails++; $display("FAIL ares_run_outs got %b want %b", outs, ALL); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_ldhzd();
    test_jump_hazard();
    test_mdu();
    test_memwait();
    test_mem_to_exwait();
    test_memstall_run();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22050078_pipectrl.md
YSYX_22050078_PIPECTRL -- requirements
Module: ysyx_22050078_pipectrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_ldhzd  input  1  load-use hazard from the bypass unit (its ID/EX bubble request).
REQ-005 i_bru_jump  input  1  branch unit redirect, resolved in ID.
REQ-006 i_ifu_valid  input  1  fetched instruction valid this cycle.
REQ-007 i_mdu_start  input  1  multi-cycle MUL/DIV issued from EX this cycle.
REQ-008 i_mdu_done  input  1  single-cycle pulse; MUL/DIV result valid.
REQ-009 i_lsu_req  input  1  LSU stage holds a memory access.
REQ-010 i_lsu_ready  input  1  memory completes the LSU access this cycle.
REQ-011 o_pc_wen, o_ifid_wen, o_idex_wen, o_exls_wen, o_lswb_wen  output  1 each  stage register write enables.
REQ-012 o_ifid_flush, o_idex_bubble, o_exls_bubble, o_lswb_bubble  output  1 each  load NOP into that pipe register.
REQ-013 o_state  output  2  FSM state: RUN=00, EXWAIT=01, MEMWAIT=10.
REQ-014 o_stall_cnt  output  CNT_W  count of cycles with o_pc_wen=0.

Function
REQ-015 The FSM SHALL have exactly three states (RUN, EXWAIT, MEMWAIT); encoding 11 SHALL never occur.
REQ-016 Internal flags SHALL be mdu_busy (set on i_mdu_start accepted in RUN, cleared on leaving EXWAIT) and mdu_done_q (set on i_mdu_done while mdu_busy, cleared on leaving EXWAIT).
REQ-017 Memory stall (i_lsu_req && !i_lsu_ready) SHALL have top priority in any state: all wen=0 except o_lswb_wen=1 with o_lswb_bubble=1; next state MEMWAIT.
REQ-018 MEMWAIT exit on i_lsu_ready: that cycle stages SHALL advance per the return state; next state EXWAIT if mdu_busy and not (mdu_done_q or i_mdu_done), else RUN.
REQ-019 EXWAIT without memory stall: o_pc_wen, o_ifid_wen, o_idex_wen=0; o_exls_wen=1 with o_exls_bubble=1; o_lswb_wen=1.
REQ-020 EXWAIT exit when mdu_done_q or i_mdu_done: that cycle all wen=1, no bubbles; next state RUN.
REQ-021 RUN, i_mdu_start, no memory stall: all wen=1 this cycle (MDU op enters EX), next state EXWAIT.
REQ-022 RUN, i_ldhzd: o_pc_wen=o_ifid_wen=0; o_idex_bubble=1; i_bru_jump SHALL be ignored that cycle.
REQ-023 RUN, i_bru_jump without i_ldhzd: o_pc_wen=1, o_ifid_flush=1.
REQ-024 RUN, !i_ifu_valid, no jump/hazard: o_pc_wen=0, o_ifid_wen=1 with o_ifid_flush=1.
REQ-025 RUN, no event: all wen=1, all bubbles/flush 0.
REQ-026 In EXWAIT/MEMWAIT, i_bru_jump, i_ldhzd, i_ifu_valid and i_mdu_start SHALL be ignored.
REQ-027 Bubble/flush SHALL only be asserted with the matching wen=1.
REQ-028 o_stall_cnt SHALL increment by 1 every cycle o_pc_wen=0 (reset excluded), wrapping to 0 at all-ones.
REQ-029 Outputs other than o_state and o_stall_cnt SHALL be combinational from state, flags and inputs (zero-cycle latency).

Reset
REQ-030 On rst_n low, immediately: state=RUN, mdu_busy=0, mdu_done_q=0, o_stall_cnt=0.
REQ-031 While rst_n low, all wen, bubble and flush outputs SHALL be 0.
REQ-032 Reset asserted mid-EXWAIT or mid-MEMWAIT SHALL abandon the stall; first cycle after release behaves as RUN.

Verification
REQ-033 i_ldhzd=1 one cycle in RUN -> o_pc_wen=0, o_ifid_wen=0, o_idex_bubble=1; o_stall_cnt 0->1; next cycle all wen=1.
REQ-034 i_mdu_start, then i_mdu_done 4 cycles later -> 4 cycles EXWAIT (o_state=01, o_exls_bubble=1), done cycle all wen=1, then RUN; o_stall_cnt=4.
REQ-035 In EXWAIT assert i_lsu_req with i_lsu_ready=0 for 3 cycles, i_mdu_done pulses during MEMWAIT -> o_state=10 for 3 cycles, o_lswb_bubble=1, then RUN (not EXWAIT).
REQ-036 i_bru_jump=1 and i_ldhzd=1 same RUN cycle -> o_ifid_flush=0, o_idex_bubble=1; next cycle jump alone -> o_ifid_flush=1, o_pc_wen=1.
REQ-037 Preload o_stall_cnt to all-ones (CNT_W=4, 15 stall cycles) then one more stall -> o_stall_cnt=0.
REQ-038 rst_n low asynchronously during MEMWAIT -> o_state=00 and all wen=0 before next clock edge; after release, no-event cycle gives all wen=1.
